// File: rtl/pe_group_pkg.sv
// Shared definitions for the PE group feeder: stream word counts, write-select codes
// and the feeder state encoding.
package pe_group_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  localparam logic [1:0] WR_SEL_W    = 2'd0;
  localparam logic [1:0] WR_SEL_I    = 2'd1;
  localparam logic [1:0] WR_SEL_O    = 2'd2;
  localparam logic [1:0] WR_SEL_NOP  = 2'd3;

  // Weight words per tile: every block carries one weight per PE in a row.
  function automatic int w_words(input int block_count, input int w_group);
    return block_count * w_group;
  endfunction

  // Input words per tile: the first block fills the whole input edge, later
  // blocks only shift in one row's worth of new inputs.
  function automatic int i_words(input int i_group, input int block_count, input int w_group);
    return i_group + (block_count - 1) * w_group;
  endfunction

  // Initial partial sums: only block 0 needs them, later blocks start from zero
  // inside the group.
  function automatic int o_words(input int o_group);
    return o_group;
  endfunction

  // One result word per output row.
  function automatic int r_words(input int o_group);
    return o_group;
  endfunction

endpackage

// File: rtl/pe_group_feeder_feed_channel.sv
// One valid/ready transmit channel: walks a word buffer from index 0 to N-1,
// one word per handshake, and flags completion after the last word.
module feed_channel
  import pe_group_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int N         = 16
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 launch_i,
  input  logic [DataWidth-1:0] words_i [N],
  input  logic                 rdy_i,
  output logic                 valid_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 fin_o
);

  localparam int PtrW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PtrW-1:0] LAST = PtrW'(N - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            valid_q, valid_d;
  logic            fin_q, fin_d;

  // Next-state: launch restarts at word 0, a handshake advances or finishes.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    fin_d   = fin_q;
    if (launch_i) begin
      ptr_d   = '0;
      valid_d = 1'b1;
      fin_d   = 1'b0;
    end else if (valid_q && rdy_i) begin
      if (ptr_q == LAST) begin
        valid_d = 1'b0;
        fin_d   = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else begin
      ptr_d   = ptr_q;
      valid_d = valid_q;
      fin_d   = fin_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (aclr) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = words_i[ptr_q];
  assign fin_o   = fin_q;

endmodule

// File: rtl/pe_group_feeder.sv
// Transmit side of a PE group: holds one tile of W/I/O words, streams them out,
// then collects the group's result words and pulses done.
module pe_group_feeder
  import pe_group_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int W_PEGroupSize = 4,
  parameter int O_PEGroupSize = 4,
  parameter int I_PEGroupSize = 7,
  parameter int BlockCount    = 4,
  parameter int AddrWidth     = 5
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 wr_en,
  input  logic [1:0]           wr_sel,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  output logic                 W_DataOutValid,
  input  logic                 W_DataOutRdy,
  output logic [DataWidth-1:0] W_DataOut,
  output logic                 I_DataOutValid,
  input  logic                 I_DataOutRdy,
  output logic [DataWidth-1:0] I_DataOut,
  output logic                 O_DataOutValid,
  input  logic                 O_DataOutRdy,
  output logic [DataWidth-1:0] O_DataOut,
  input  logic                 R_DataInValid,
  output logic                 R_DataInRdy,
  input  logic [DataWidth-1:0] R_DataIn,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  localparam int W_WORDS = w_words(BlockCount, W_PEGroupSize);
  localparam int I_WORDS = i_words(I_PEGroupSize, BlockCount, W_PEGroupSize);
  localparam int O_WORDS = o_words(O_PEGroupSize);
  localparam int R_WORDS = r_words(O_PEGroupSize);
  localparam int WIDX_W  = (W_WORDS > 1) ? $clog2(W_WORDS) : 1;
  localparam int IIDX_W  = (I_WORDS > 1) ? $clog2(I_WORDS) : 1;
  localparam int OIDX_W  = (O_WORDS > 1) ? $clog2(O_WORDS) : 1;
  localparam int RIDX_W  = (R_WORDS > 1) ? $clog2(R_WORDS) : 1;
  localparam int RCNT_W  = $clog2(R_WORDS + 1);

  feeder_state_e state_q, state_d;
  logic          busy_q, done_q;

  logic [DataWidth-1:0] w_buf_q      [W_WORDS];
  logic [DataWidth-1:0] i_buf_q      [I_WORDS];
  logic [DataWidth-1:0] o_buf_q      [O_WORDS];
  logic [DataWidth-1:0] result_buf_q [R_WORDS];
  logic [RCNT_W-1:0]    rcnt_q, rcnt_d;

  logic launch_s, wr_ok_s, r_hs_s, all_fin_s;
  logic w_fin_s, i_fin_s, o_fin_s;

  // Buffers are only writable while idle so a tile in flight never changes under the streams.
  assign launch_s  = start && (state_q == ST_IDLE);
  assign wr_ok_s   = wr_en && (state_q == ST_IDLE);
  assign all_fin_s = w_fin_s && i_fin_s && o_fin_s;

  // Tile buffer writes; out-of-range addresses are dropped, contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s && (wr_sel == WR_SEL_W) && (wr_addr < AddrWidth'(W_WORDS))) begin
      w_buf_q[wr_addr[WIDX_W-1:0]] <= wr_data;
    end
    if (wr_ok_s && (wr_sel == WR_SEL_I) && (wr_addr < AddrWidth'(I_WORDS))) begin
      i_buf_q[wr_addr[IIDX_W-1:0]] <= wr_data;
    end
    if (wr_ok_s && (wr_sel == WR_SEL_O) && (wr_addr < AddrWidth'(O_WORDS))) begin
      o_buf_q[wr_addr[OIDX_W-1:0]] <= wr_data;
    end
  end

  feed_channel #(.DataWidth(DataWidth), .N(W_WORDS)) u_w_chan (
    .clk(clk), .aclr(aclr), .launch_i(launch_s), .words_i(w_buf_q), .rdy_i(W_DataOutRdy),
    .valid_o(W_DataOutValid), .data_o(W_DataOut), .fin_o(w_fin_s)
  );

  feed_channel #(.DataWidth(DataWidth), .N(I_WORDS)) u_i_chan (
    .clk(clk), .aclr(aclr), .launch_i(launch_s), .words_i(i_buf_q), .rdy_i(I_DataOutRdy),
    .valid_o(I_DataOutValid), .data_o(I_DataOut), .fin_o(i_fin_s)
  );

  feed_channel #(.DataWidth(DataWidth), .N(O_WORDS)) u_o_chan (
    .clk(clk), .aclr(aclr), .launch_i(launch_s), .words_i(o_buf_q), .rdy_i(O_DataOutRdy),
    .valid_o(O_DataOutValid), .data_o(O_DataOut), .fin_o(o_fin_s)
  );

  // Results are accepted during SEND too, since the group may finish early rows quickly.
  assign R_DataInRdy = ((state_q == ST_SEND) || (state_q == ST_DRAIN)) &&
                       (rcnt_q < RCNT_W'(R_WORDS));
  assign r_hs_s      = R_DataInValid && R_DataInRdy;

  // Result counter next value: cleared on launch, bumped on each accepted word.
  always_comb begin
    rcnt_d = rcnt_q;
    if (launch_s) begin
      rcnt_d = '0;
    end else if (r_hs_s) begin
      rcnt_d = rcnt_q + 1'b1;
    end else begin
      rcnt_d = rcnt_q;
    end
  end

  // Result capture into the readback buffer.
  always_ff @(posedge clk) begin
    if (aclr) begin
      rcnt_q <= '0;
      for (int k = 0; k < R_WORDS; k++) begin
        result_buf_q[k] <= '0;
      end
    end else begin
      rcnt_q <= rcnt_d;
      if (r_hs_s) begin
        result_buf_q[rcnt_q[RIDX_W-1:0]] <= R_DataIn;
      end
    end
  end

  // Readback mux; reads see the value before any same-cycle capture.
  always_comb begin
    rd_data = '0;
    if (rd_addr < AddrWidth'(R_WORDS)) begin
      rd_data = result_buf_q[rd_addr[RIDX_W-1:0]];
    end else begin
      rd_data = '0;
    end
  end

  // FSM next state: send all streams, wait for every result, then one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SEND;
        else       state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (all_fin_s) state_d = ST_DRAIN;
        else           state_d = ST_SEND;
      end
      ST_DRAIN: begin
        if (rcnt_q == RCNT_W'(R_WORDS)) state_d = ST_DONE;
        else                            state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_SEND) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pe_group_feeder.sv
// Directed bench for pe_group_feeder: stream order, backpressure, result capture,
// busy-time interference, mid-tile reset and out-of-range addressing.
module tb_pe_group_feeder;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          aclr, start, busy, done, wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          W_DataOutValid, W_DataOutRdy, I_DataOutValid, I_DataOutRdy;
  logic          O_DataOutValid, O_DataOutRdy, R_DataInValid, R_DataInRdy;
  logic [DW-1:0] W_DataOut, I_DataOut, O_DataOut, R_DataIn;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pe_group_feeder dut (
    .clk(clk), .aclr(aclr), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .W_DataOutValid(W_DataOutValid), .W_DataOutRdy(W_DataOutRdy), .W_DataOut(W_DataOut),
    .I_DataOutValid(I_DataOutValid), .I_DataOutRdy(I_DataOutRdy), .I_DataOut(I_DataOut),
    .O_DataOutValid(O_DataOutValid), .O_DataOutRdy(O_DataOutRdy), .O_DataOut(O_DataOut),
    .R_DataInValid(R_DataInValid), .R_DataInRdy(R_DataInRdy), .R_DataIn(R_DataIn),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // All ready high: W words on cycles 1..16, I on 1..19, O on 1..4, in address order.
  task automatic run_all_ready();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("W_valid c%0d", c), 32'(W_DataOutValid), 32'(c <= 16));
      if (c <= 16) check($sformatf("W_data c%0d", c), W_DataOut, 32'h100 + 32'(c - 1));
      check($sformatf("I_valid c%0d", c), 32'(I_DataOutValid), 32'(c <= 19));
      if (c <= 19) check($sformatf("I_data c%0d", c), I_DataOut, 32'h200 + 32'(c - 1));
      check($sformatf("O_valid c%0d", c), 32'(O_DataOutValid), 32'(c <= 4));
      if (c <= 4) check($sformatf("O_data c%0d", c), O_DataOut, 32'h300 + 32'(c - 1));
      if (c == 1) check("R_rdy_send", 32'(R_DataInRdy), 32'd1);
      check($sformatf("busy c%0d", c), 32'(busy), 32'd1);
    end
  endtask

  // Four results, then a refused fifth word, a one-cycle done pulse and readback.
  task automatic feed_results(input logic [DW-1:0] base);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      R_DataInValid = 1'b1;
      R_DataIn      = base + DW'(k);
      check($sformatf("R_rdy k%0d", k), 32'(R_DataInRdy), 32'd1);
      check($sformatf("done_early k%0d", k), 32'(done), 32'd0);
    end
    @(negedge clk);
    R_DataIn = base + 32'd4;
    check("R_rdy_full", 32'(R_DataInRdy), 32'd0);
    check("done_before", 32'(done), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("R_rdy_done", 32'(R_DataInRdy), 32'd0);
    R_DataInValid = 1'b0;
    @(negedge clk);
    check("done_after", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd_addr = AW'(k);
      #1 check($sformatf("rd_data %0d", k), rd_data, base + DW'(k));
    end
  endtask

  initial begin
    logic [DW-1:0] prev;
    logic          hold_pending;
    logic          wdone;
    int            idx;

    aclr = 1'b1; start = 1'b0; wr_en = 1'b0; wr_sel = 2'd3; wr_addr = '0; wr_data = '0;
    W_DataOutRdy = 1'b0; I_DataOutRdy = 1'b0; O_DataOutRdy = 1'b0;
    R_DataInValid = 1'b0; R_DataIn = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_W_valid", 32'(W_DataOutValid), 32'd0);
    check("rst_I_valid", 32'(I_DataOutValid), 32'd0);
    check("rst_O_valid", 32'(O_DataOutValid), 32'd0);
    check("rst_R_rdy", 32'(R_DataInRdy), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    aclr = 1'b0;

    for (int k = 0; k < 16; k++) wr(2'd0, AW'(k), 32'h100 + 32'(k));
    for (int k = 0; k < 19; k++) wr(2'd1, AW'(k), 32'h200 + 32'(k));
    for (int k = 0; k < 4; k++)  wr(2'd2, AW'(k), 32'h300 + 32'(k));

    // Tile 1: full-rate streams, then results.
    W_DataOutRdy = 1'b1; I_DataOutRdy = 1'b1; O_DataOutRdy = 1'b1;
    pulse_start();
    run_all_ready();
    feed_results(32'hA0);

    // Tile 2: W backpressure 1-0, with start and a write attempt during SEND.
    W_DataOutRdy = 1'b0;
    pulse_start();
    idx = 0; hold_pending = 1'b0; wdone = 1'b0; prev = '0;
    for (int cyc = 1; cyc <= 60 && !wdone; cyc++) begin
      @(negedge clk);
      W_DataOutRdy = cyc[0];
      if (cyc == 3) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 2'd0; wr_addr = '0; wr_data = 32'hDEAD;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      if (W_DataOutValid) begin
        if (hold_pending) check("W_hold", W_DataOut, prev);
        if (W_DataOutRdy) begin
          check($sformatf("W_seq %0d", idx), W_DataOut, 32'h100 + 32'(idx));
          idx++;
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          prev = W_DataOut;
        end
      end else begin
        if (idx > 0) wdone = 1'b1;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    check("W_count", 32'(idx), 32'd16);
    check("W_stream_end", 32'(wdone), 32'd1);
    feed_results(32'hB0);

    // Tile 3: reset on cycle 5 of SEND.
    W_DataOutRdy = 1'b1;
    pulse_start();
    repeat (4) @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("aclr_W_valid", 32'(W_DataOutValid), 32'd0);
    check("aclr_I_valid", 32'(I_DataOutValid), 32'd0);
    check("aclr_O_valid", 32'(O_DataOutValid), 32'd0);
    check("aclr_busy", 32'(busy), 32'd0);
    check("aclr_done", 32'(done), 32'd0);
    check("aclr_R_rdy", 32'(R_DataInRdy), 32'd0);
    rd_addr = '0;
    #1 check("aclr_result_clr", rd_data, 32'd0);
    aclr = 1'b0;
    @(negedge clk);
    check("aclr_no_done", 32'(done), 32'd0);

    // Out-of-range write and readback.
    wr(2'd1, AW'(31), 32'hBAD);
    rd_addr = AW'(7);
    #1 check("rd_oob", rd_data, 32'd0);

    // Restart with surviving buffers: W[0] must still be 0x100, I[18] still 0x212.
    pulse_start();
    run_all_ready();
    feed_results(32'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
